adder_pipe_nbit: RTL and testbench

- Parametrised, pipelined N-bit add/subtract unit. Successor to the single-cycle combinational ripple-carry adder.
- The carry chain is split into STAGES equal slices, with one register boundary per slice, so wide adds close timing.
- Valid/ready streaming handshake with per-stage backpressure. Sits between operand producers and a downstream consumer in the datapath.

---
 rtl/adder_pipe_nbit.sv | 153 +++++++++++++++
 tb/tb_adder_pipe_nbit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit add/subtract unit: the carry chain is cut into STAGES slices with a
// valid/ready register boundary per slice. Define ADDER_PIPE_OVF_EN to add the overflow output.
module adder_pipe_nbit #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         carry_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry_out
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic         overflow
`endif
);

    localparam int W = N / STAGES;

    logic [STAGES-1:0] v_all_s;
    logic [STAGES-1:0] rdy_all_s;
    logic              chain_rdy_s;

    function automatic logic [W:0] slice_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    // Backpressure chain: a stage is ready when empty or when the stage after it can move.
    always_comb begin
        rdy_all_s   = {STAGES{1'b0}};
        chain_rdy_s = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_rdy_s  = ~v_all_s[k] | chain_rdy_s;
            rdy_all_s[k] = chain_rdy_s;
        end
    end

    assign in_ready = rdy_all_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when a beat enters this stage, and bits kept after it.
        localparam int REM_W  = N - k * W;
        localparam int HOLD_W = N - (k + 1) * W;

        logic [REM_W-1:0]   op_a_s;
        logic [REM_W-1:0]   op_b_s;
        logic               cin_s;
        logic               up_v_s;
        logic               ld_s;
        logic [W:0]         add_s;
        logic [(k+1)*W-1:0] s_d;
        logic [(k+1)*W-1:0] s_q;
        logic               c_q;
        logic               v_q;

        if (k == 0) begin : g_src
            assign op_a_s = A;
            assign op_b_s = B ^ {N{sub}};
            assign cin_s  = carry_in ^ sub;
            assign up_v_s = in_valid;
            assign s_d    = add_s[W-1:0];
        end else begin : g_chain
            assign op_a_s = g_stage[k-1].g_hold.a_q;
            assign op_b_s = g_stage[k-1].g_hold.b_q;
            assign cin_s  = g_stage[k-1].c_q;
            assign up_v_s = v_all_s[k-1];
            assign s_d    = {add_s[W-1:0], g_stage[k-1].s_q};
        end

        assign add_s      = slice_add(op_a_s[W-1:0], op_b_s[W-1:0], cin_s);
        assign ld_s       = rdy_all_s[k] & up_v_s;
        assign v_all_s[k] = v_q;

        // Stage valid, completed sum slices and slice carry.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= {((k+1)*W){1'b0}};
                c_q <= 1'b0;
            end else begin
                if (rdy_all_s[k]) begin
                    v_q <= up_v_s;
                end else begin
                    v_q <= v_q;
                end
                if (ld_s) begin
                    s_q <= s_d;
                    c_q <= add_s[W];
                end else begin
                    s_q <= s_q;
                    c_q <= c_q;
                end
            end
        end

        if (k < STAGES - 1) begin : g_hold
            logic [HOLD_W-1:0] a_q;
            logic [HOLD_W-1:0] b_q;

            // Upper operand slices not yet consumed travel with the beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= {HOLD_W{1'b0}};
                    b_q <= {HOLD_W{1'b0}};
                end else if (ld_s) begin
                    a_q <= op_a_s[REM_W-1:W];
                    b_q <= op_b_s[REM_W-1:W];
                end else begin
                    a_q <= a_q;
                    b_q <= b_q;
                end
            end
        end

        if (k == STAGES - 1) begin : g_out
            assign out_valid = v_q;
            assign sum       = s_q;
            assign carry_out = c_q;
        end

`ifdef ADDER_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic msb_cin_s;
            logic ovf_q;

            // The carry into bit N-1 is recovered from the sum bit and both operand bits.
            assign msb_cin_s = op_a_s[W-1] ^ op_b_s[W-1] ^ add_s[W-1];

            // Signed overflow, registered alongside the final sum slice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (ld_s) begin
                    ovf_q <= msb_cin_s ^ add_s[W];
                end else begin
                    ovf_q <= ovf_q;
                end
            end

            assign overflow = ovf_q;
        end
`endif
    end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Self-checking bench for adder_pipe_nbit: directed vector table, streaming, backpressure,
// mid-stream reset and randomized traffic against an arithmetic reference queue.
module tb_adder_pipe_nbit;

    localparam int N = 8;
`ifdef ADDER_PIPE_OVF_EN
    localparam int STAGES = 4;
`else
    localparam int STAGES = 2;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry_out;
`ifdef ADDER_PIPE_OVF_EN
    logic         overflow;
`endif

    adder_pipe_nbit #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef ADDER_PIPE_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sb;
        logic [N-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         q[$];
    vec_t         tbl[10];
    logic         prev_hold = 1'b0;
    logic [N-1:0] prev_sum;
    logic         prev_co;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry and signed range for overflow.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic ci, input logic sb);
        int   ua, ub, tot, sa, sbv, st, c;
        exp_t r;
        ua  = int'(a);
        ub  = int'(b);
        if (sb) ub = (2 ** N - 1) - ub;
        c   = (ci ^ sb) ? 1 : 0;
        tot = ua + ub + c;
        r.s  = N'(tot % (2 ** N));
        r.co = (tot >= 2 ** N);
        sa  = (ua >= 2 ** (N - 1)) ? ua - 2 ** N : ua;
        sbv = (ub >= 2 ** (N - 1)) ? ub - 2 ** N : ub;
        st  = sa + sbv + c;
        r.ov = (st > 2 ** (N - 1) - 1) || (st < -(2 ** (N - 1)));
        return r;
    endfunction

    // One clock of model-tracked traffic; entered and left at a falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (q.size() == 0) begin
            chk("empty_in_ready", 32'(in_ready), 32'd1);
            chk("empty_out_valid", 32'(out_valid), 32'd0);
        end else if (q.size() == STAGES) begin
            chk("full_in_ready", 32'(in_ready), 32'(out_ready));
        end
        if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(prev_sum));
            chk("hold_co", 32'(carry_out), 32'(prev_co));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_beat: got sum %0h, expected no beat", sum);
            end else begin
                e = q.pop_front();
                chk("beat_sum", 32'(sum), 32'(e.s));
                chk("beat_co", 32'(carry_out), 32'(e.co));
`ifdef ADDER_PIPE_OVF_EN
                chk("beat_ov", 32'(overflow), 32'(e.ov));
`endif
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_sum  = sum;
        prev_co   = carry_out;
        if (in_valid && in_ready) q.push_back(model(A, B, carry_in, sub));
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (q.size() != 0 && budget < 40) begin
            cycle();
            budget++;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[8] = '{8'hA5, 8'h5A, 1'b0, 1'b1, 8'h4B, 1'b1, 1'b1};
        tbl[9] = '{8'h12, 8'h34, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = 8'h00; B = 8'h00; carry_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_co", 32'(carry_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDER_PIPE_OVF_EN
        chk("rst_ov", 32'(overflow), 32'd0);
`endif
        @(negedge clk);

        // Directed vectors, one at a time, with exact latency checks.
        for (int i = 0; i < 10; i++) begin
            A = tbl[i].a; B = tbl[i].b; carry_in = tbl[i].cin; sub = tbl[i].sb;
            in_valid = 1'b1; out_ready = 1'b1;
            #1 chk("tbl_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            A = N'($urandom); B = N'($urandom);
            for (int j = 1; j <= STAGES; j++) begin
                #1 chk("tbl_latency", 32'(out_valid), (j == STAGES) ? 32'd1 : 32'd0);
                if (j == STAGES) begin
                    chk("tbl_sum", 32'(sum), 32'(tbl[i].s));
                    chk("tbl_co", 32'(carry_out), 32'(tbl[i].co));
`ifdef ADDER_PIPE_OVF_EN
                    chk("tbl_ov", 32'(overflow), 32'(tbl[i].ov));
`endif
                end
                @(negedge clk);
            end
            #1 chk("tbl_consumed", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Four back-to-back beats, results on consecutive cycles.
        carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 4 + STAGES; j++) begin
            if (j < 4) begin
                A = N'(j + 1); B = N'(j + 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (j < 4) chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (j >= STAGES) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_sum", 32'(sum), 32'(2 * (j - STAGES + 1)));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: pipeline fills with STAGES beats, then drains in order.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            A = N'($urandom); B = N'($urandom);
            carry_in = 1'($urandom); sub = 1'($urandom);
            cycle();
        end
        chk("bp_accepted", 32'(q.size()), 32'(STAGES));
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            A = N'($urandom); B = N'($urandom);
            carry_in = 1'($urandom); sub = 1'($urandom);
            cycle();
        end
        drain("bp_drain");

        // Reset with two beats in flight; they must never surface.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            A = N'($urandom); B = N'($urandom);
            carry_in = 1'($urandom); sub = 1'($urandom);
            cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_co", 32'(carry_out), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDER_PIPE_OVF_EN
        chk("mid_rst_ov", 32'(overflow), 32'd0);
`endif
        q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 2 * STAGES; c++) cycle();

        // Randomized traffic with random stalls on both sides.
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            A = N'($urandom); B = N'($urandom);
            carry_in = 1'($urandom); sub = 1'($urandom);
            cycle();
        end
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "timeout");
    end

endmodule
